alu_share_arbiter: RTL and testbench

Shares one combinational 64-bit ALU between NREQ requesters, such as the decode/execute path and a branch-compare or address helper. Each requester uses a valid/ready request port and a valid/ready response port. The block grants round-robin, registers operands, drives the external ALU for one cycle and returns a registered result. It sits beside the ALU in the datapath and owns the ALU's a/b/ALUOp inputs.

---
 rtl/alu_share_arbiter_pkg.sv | 27 ++
 rtl/alu_64.sv | 23 ++
 rtl/alu_share_arbiter_rr_arbiter.sv | 29 ++
 rtl/alu_share_arbiter.sv | 127 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALUOp encodings, the
// legal-op check and the FSM state type.
package alu_share_arbiter_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

    // True when op is one of the five ALUOp codes the ALU implements.
    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR: legal = 1'b1;
            default:                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_64.sv
// 64-bit combinational ALU. Unimplemented ALUOp codes return zero.
module alu_64
    import alu_share_arbiter_pkg::*;
(
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic [3:0]  op_i,
    output logic [63:0] result_o
);

    // Decode ALUOp into the selected operation.
    always_comb begin
        case (op_i)
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_NOR: result_o = ~(a_i | b_i);
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at
// or after ptr_i, wrapping modulo NREQ. Reusable for any shared resource.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [NREQ-1:0] grant_o
);

    int unsigned idx;
    logic        found;

    // Scan upward from the pointer and take the first active request.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr_i) + i) % NREQ;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between NREQ requesters. Grants
// round-robin in IDLE, drives the ALU from captured operands for one EXEC
// cycle, then holds a registered response until its owner consumes it.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned NREQ  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*4-1:0] req_op,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [WIDTH-1:0]  resp_result,
    output logic              resp_zero,
    output logic              resp_err,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [3:0]        alu_op,
    input  logic [WIDTH-1:0]  alu_result
);

    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state_q;
    logic [PtrW-1:0]   ptr_q;
    logic [PtrW-1:0]   owner_q;
    logic [WIDTH-1:0]  cap_a_q;
    logic [WIDTH-1:0]  cap_b_q;
    logic [3:0]        cap_op_q;
    logic [WIDTH-1:0]  resp_result_q;
    logic              resp_zero_q;
    logic              resp_err_q;
    logic [NREQ-1:0]   resp_valid_q;

    logic [NREQ-1:0]   grant;
    logic [PtrW-1:0]   grant_idx;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;
    logic [3:0]        sel_op;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    // Encode the one-hot grant and mux the granted requester's operands.
    always_comb begin
        grant_idx = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_op    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                grant_idx = PtrW'(i);
                sel_a     = req_a[i*WIDTH +: WIDTH];
                sel_b     = req_b[i*WIDTH +: WIDTH];
                sel_op    = req_op[i*4 +: 4];
            end
        end
    end

    // Accept only in IDLE, and never while reset is asserted.
    always_comb begin
        req_ready = (state_q == StIdle && !reset) ? grant : '0;
    end

    // Sequencer: capture on handshake, sample ALU in EXEC, hold until popped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            owner_q       <= '0;
            cap_a_q       <= '0;
            cap_b_q       <= '0;
            cap_op_q      <= '0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_valid_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (|req_ready) begin
                        cap_a_q  <= sel_a;
                        cap_b_q  <= sel_b;
                        cap_op_q <= sel_op;
                        owner_q  <= grant_idx;
                        state_q  <= StExec;
                    end
                end
                StExec: begin
                    resp_result_q <= alu_result;
                    resp_zero_q   <= (alu_result == '0);
                    resp_err_q    <= !is_legal_op(cap_op_q);
                    resp_valid_q  <= NREQ'(1) << owner_q;
                    state_q       <= StResp;
                end
                StResp: begin
                    if (resp_ready[owner_q]) begin
                        resp_valid_q <= '0;
                        ptr_q        <= (owner_q == PtrW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign alu_a       = cap_a_q;
    assign alu_b       = cap_b_q;
    assign alu_op      = cap_op_q;
    assign resp_valid  = resp_valid_q;
    assign resp_result = resp_result_q;
    assign resp_zero   = resp_zero_q;
    assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with the real alu_64 attached.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [7:0]   req_op;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready;
    logic [63:0]  resp_result;
    logic         resp_zero;
    logic         resp_err;
    logic [63:0]  alu_a;
    logic [63:0]  alu_b;
    logic [3:0]   alu_op;
    logic [63:0]  alu_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(
        .WIDTH (64),
        .NREQ  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp_err    (resp_err),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result)
    );

    alu_64 u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .op_i     (alu_op),
        .result_o (alu_result)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated transaction on requester idx, popped as soon as it appears.
    task automatic run_one(input int idx, input logic [63:0] a, input logic [63:0] b,
                           input logic [3:0] op, input logic [63:0] exp_res,
                           input logic exp_zero, input logic exp_err, input string tag);
        logic [63:0] onehot;
        onehot = 64'(1) << idx;
        req_a[idx*64 +: 64] = a;
        req_b[idx*64 +: 64] = b;
        req_op[idx*4 +: 4]  = op;
        req_valid           = '0;
        req_valid[idx]      = 1'b1;
        #1;
        chk({tag, " req_ready"}, 64'(req_ready), onehot);
        step();
        req_valid = '0;
        chk({tag, " exec alu_a"}, alu_a, a);
        chk({tag, " exec alu_op"}, 64'(alu_op), 64'(op));
        chk({tag, " exec no resp"}, 64'(resp_valid), 64'd0);
        step();
        chk({tag, " resp_valid"}, 64'(resp_valid), onehot);
        chk({tag, " result"}, resp_result, exp_res);
        chk({tag, " zero"}, 64'(resp_zero), 64'(exp_zero));
        chk({tag, " err"}, 64'(resp_err), 64'(exp_err));
        resp_ready[idx] = 1'b1;
        step();
        resp_ready = '0;
        chk({tag, " popped"}, 64'(resp_valid), 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 2'b11;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = '0;

        // Reset state, including req_ready gated while reset is high.
        step();
        step();
        chk("rst req_ready", 64'(req_ready), 64'd0);
        chk("rst resp_valid", 64'(resp_valid), 64'd0);
        chk("rst alu_a", alu_a, 64'd0);
        chk("rst alu_op", 64'(alu_op), 64'd0);
        chk("rst resp_result", resp_result, 64'd0);
        req_valid = '0;
        reset     = 1'b0;
        #1;
        chk("post rst resp_valid", 64'(resp_valid), 64'd0);

        // Single-requester functional vectors.
        run_one(0, 64'd5, 64'd7, ALU_ADD, 64'd12, 1'b0, 1'b0, "add5_7");
        run_one(0, 64'h10, 64'h10, ALU_SUB, 64'd0, 1'b1, 1'b0, "sub_eq");
        run_one(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADD, 64'd0, 1'b1, 1'b0, "add_ovf");
        run_one(0, 64'd0, 64'd0, ALU_NOR, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, "nor0");
        run_one(1, 64'hF0F0, 64'hFF00, ALU_AND, 64'hF000, 1'b0, 1'b0, "and");
        run_one(0, 64'hF0F0, 64'h0F0F, ALU_OR, 64'hFFFF, 1'b0, 1'b0, "or");
        run_one(1, 64'd3, 64'd4, 4'b0111, 64'd0, 1'b1, 1'b1, "illegal");

        // Contention from reset: grants alternate 0,1,0,1.
        reset = 1'b1;
        step();
        req_a      = {64'd10, 64'd1};
        req_b      = {64'd20, 64'd1};
        req_op     = {ALU_ADD, ALU_ADD};
        resp_ready = 2'b11;
        req_valid  = 2'b11;
        reset      = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr grant", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
            step();
            step();
            chk("rr owner", 64'(resp_valid), (k % 2 == 0) ? 64'd1 : 64'd2);
            chk("rr result", resp_result, (k % 2 == 0) ? 64'd2 : 64'd30);
            step();
        end

        // Backpressure on requester 0 while requester 1 waits.
        reset = 1'b1;
        step();
        reset      = 1'b0;
        resp_ready = '0;
        req_a      = {64'd7, 64'd100};
        req_b      = {64'd8, 64'd1};
        req_op     = {ALU_AND, ALU_SUB};
        req_valid  = 2'b11;
        #1;
        chk("bp grant0", 64'(req_ready), 64'd1);
        step();
        step();
        chk("bp resp_valid", 64'(resp_valid), 64'd1);
        chk("bp result", resp_result, 64'd99);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp hold valid", 64'(resp_valid), 64'd1);
            chk("bp hold result", resp_result, 64'd99);
            chk("bp no ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 2'b01;
        step();
        resp_ready = '0;
        chk("bp grant1 after pop", 64'(req_ready), 64'd2);

        // Reset during EXEC of requester 1's transaction.
        step();
        chk("exec alu_a", alu_a, 64'd7);
        reset = 1'b1;
        #1;
        chk("midrst alu_a", alu_a, 64'd0);
        chk("midrst alu_op", 64'(alu_op), 64'd0);
        chk("midrst resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst req_ready", 64'(req_ready), 64'd0);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("post midrst grant0", 64'(req_ready), 64'd1);
        req_valid = '0;
        step();
        chk("no stale resp 1", 64'(resp_valid), 64'd0);
        step();
        chk("no stale resp 2", 64'(resp_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
